// File: rtl/fp_min_pipe_if.sv
// fp_min_pipe_if: handshake and operand/result bundle for fp_min_pipe.
//   Input side : in_valid, in_ready, a_sign/a_expo/a_mant, b_sign/b_expo/b_mant
//   Output side: out_valid, out_ready, res_sign/res_expo/res_mant, res_nv
//   slave  modport : the min unit (consumes operands, produces results)
//   master modport : the surrounding datapath (produces operands, consumes results)
interface fp_min_pipe_if #(
   parameter int unsigned SIGN_W = 1,
   parameter int unsigned EXPO_W = 8,
   parameter int unsigned MANT_W = 23
);
   logic              in_valid;
   logic              in_ready;
   logic [SIGN_W-1:0] a_sign;
   logic [EXPO_W-1:0] a_expo;
   logic [MANT_W-1:0] a_mant;
   logic [SIGN_W-1:0] b_sign;
   logic [EXPO_W-1:0] b_expo;
   logic [MANT_W-1:0] b_mant;
   logic              out_valid;
   logic              out_ready;
   logic [SIGN_W-1:0] res_sign;
   logic [EXPO_W-1:0] res_expo;
   logic [MANT_W-1:0] res_mant;
   logic              res_nv;

   modport slave (
      input  in_valid, a_sign, a_expo, a_mant, b_sign, b_expo, b_mant, out_ready,
      output in_ready, out_valid, res_sign, res_expo, res_mant, res_nv
   );

   modport master (
      output in_valid, a_sign, a_expo, a_mant, b_sign, b_expo, b_mant, out_ready,
      input  in_ready, out_valid, res_sign, res_expo, res_mant, res_nv
   );
endinterface

// File: rtl/fp_min_pipe.sv
// fp_min_pipe: two-stage pipelined IEEE-754 minimumNumber (RISC-V FMIN) on unpacked fields.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : fp_min_pipe_if.slave -- operand pair in (valid/ready), result out (valid/ready)
// S1 registers operands, NaN class bits and the magnitude compare; S2 registers the
// selected result and the invalid flag. SIGN_W must be 1.
module fp_min_pipe #(
   parameter int unsigned SIGN_W = 1,
   parameter int unsigned EXPO_W = 8,
   parameter int unsigned MANT_W = 23
) (
   input logic          clk,
   input logic          rst,
   fp_min_pipe_if.slave bus
);
   localparam int unsigned MagW = EXPO_W + MANT_W;

   // Stage enables: a stage loads when empty or when its contents move on.
   logic s1_valid, s2_valid;
   logic s1_en, s2_en;

   assign s2_en        = !s2_valid || bus.out_ready;
   assign s1_en        = !s1_valid || s2_en;
   assign bus.in_ready = s1_en;

   // Input classification.
   logic            a_nan, b_nan, a_snan, b_snan;
   logic [MagW-1:0] a_mag, b_mag;

   assign a_nan  = (&bus.a_expo) && (|bus.a_mant);
   assign b_nan  = (&bus.b_expo) && (|bus.b_mant);
   assign a_snan = a_nan && !bus.a_mant[MANT_W-1];
   assign b_snan = b_nan && !bus.b_mant[MANT_W-1];
   assign a_mag  = {bus.a_expo, bus.a_mant};
   assign b_mag  = {bus.b_expo, bus.b_mant};

   // Stage 1 state.
   logic [SIGN_W-1:0] s1_a_sign, s1_b_sign;
   logic [EXPO_W-1:0] s1_a_expo, s1_b_expo;
   logic [MANT_W-1:0] s1_a_mant, s1_b_mant;
   logic              s1_a_nan, s1_b_nan, s1_nv;
   logic              s1_a_le_b, s1_b_le_a;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_a_sign <= '0;
         s1_a_expo <= '0;
         s1_a_mant <= '0;
         s1_b_sign <= '0;
         s1_b_expo <= '0;
         s1_b_mant <= '0;
         s1_a_nan  <= 1'b0;
         s1_b_nan  <= 1'b0;
         s1_nv     <= 1'b0;
         s1_a_le_b <= 1'b0;
         s1_b_le_a <= 1'b0;
      end else if (s1_en) begin
         s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            s1_a_sign <= bus.a_sign;
            s1_a_expo <= bus.a_expo;
            s1_a_mant <= bus.a_mant;
            s1_b_sign <= bus.b_sign;
            s1_b_expo <= bus.b_expo;
            s1_b_mant <= bus.b_mant;
            s1_a_nan  <= a_nan;
            s1_b_nan  <= b_nan;
            s1_nv     <= a_snan || b_snan;
            s1_a_le_b <= (a_mag <= b_mag);
            s1_b_le_a <= (b_mag <= a_mag);
         end
      end
   end

   // Result selection from S1 contents.
   logic              pick_a, canon;
   logic [SIGN_W-1:0] sel_sign;
   logic [EXPO_W-1:0] sel_expo;
   logic [MANT_W-1:0] sel_mant;

   always_comb begin
      pick_a = 1'b1;
      canon  = 1'b0;
      if (s1_a_nan && s1_b_nan) begin
         canon = 1'b1;
      end else if (s1_a_nan) begin
         pick_a = 1'b0;
      end else if (s1_b_nan) begin
         pick_a = 1'b1;
      end else if (s1_a_sign != s1_b_sign) begin
         pick_a = s1_a_sign[0];
      end else if (s1_a_sign[0] == 1'b0) begin
         // Positive: smaller magnitude wins; ties go to A.
         pick_a = s1_a_le_b;
      end else begin
         // Negative: larger magnitude wins; ties go to A.
         pick_a = s1_b_le_a;
      end

      if (canon) begin
         sel_sign           = '0;
         sel_expo           = '1;
         sel_mant           = '0;
         sel_mant[MANT_W-1] = 1'b1;
      end else if (pick_a) begin
         sel_sign = s1_a_sign;
         sel_expo = s1_a_expo;
         sel_mant = s1_a_mant;
      end else begin
         sel_sign = s1_b_sign;
         sel_expo = s1_b_expo;
         sel_mant = s1_b_mant;
      end
   end

   // Stage 2 state drives the outputs directly.
   logic [SIGN_W-1:0] s2_sign;
   logic [EXPO_W-1:0] s2_expo;
   logic [MANT_W-1:0] s2_mant;
   logic              s2_nv;

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_sign  <= '0;
         s2_expo  <= '0;
         s2_mant  <= '0;
         s2_nv    <= 1'b0;
      end else if (s2_en) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_sign <= sel_sign;
            s2_expo <= sel_expo;
            s2_mant <= sel_mant;
            s2_nv   <= s1_nv;
         end
      end
   end

   assign bus.out_valid = s2_valid;
   assign bus.res_sign  = s2_sign;
   assign bus.res_expo  = s2_expo;
   assign bus.res_mant  = s2_mant;
   assign bus.res_nv    = s2_nv;
endmodule

// File: tb/tb_fp_min_pipe.sv
// tb_fp_min_pipe: scoreboard bench for fp_min_pipe. Stimulus pushes the hand-computed
// result into a queue on each accepted pair; a monitor pops and compares on each output
// transfer, also checking latency and result stability under backpressure.
module tb_fp_min_pipe;
   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   fp_min_pipe_if #(.SIGN_W(1), .EXPO_W(8), .MANT_W(23)) bus ();

   fp_min_pipe #(.SIGN_W(1), .EXPO_W(8), .MANT_W(23)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic [31:0] r;
      logic        nv;
      logic [31:0] acc;
      logic        exact;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [31:0] cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Directed vectors: A, B, expected result, expected invalid flag.
   localparam int NV = 16;
   logic [31:0] va [NV] = '{32'h3F800000, 32'h00000000, 32'h80000000, 32'h7FC00001,
                            32'h7F800001, 32'h7F800001, 32'h3FC00000, 32'h7FC00000,
                            32'h40000000, 32'hC0000000, 32'h7F800000, 32'hFF800000,
                            32'h00000001, 32'h80000001, 32'h3F800000, 32'hFFC00000};
   logic [31:0] vb [NV] = '{32'hC0000000, 32'h80000000, 32'h00000000, 32'h3FC00000,
                            32'h3FC00000, 32'h7F800002, 32'h7FA00000, 32'h7FC00000,
                            32'h3F800000, 32'hBF800000, 32'h7F7FFFFF, 32'h00000001,
                            32'h00000002, 32'h80000002, 32'h3F800000, 32'hBF800000};
   logic [31:0] vr [NV] = '{32'hC0000000, 32'h80000000, 32'h80000000, 32'h3FC00000,
                            32'h3FC00000, 32'h7FC00000, 32'h3FC00000, 32'h7FC00000,
                            32'h3F800000, 32'hC0000000, 32'h7F7FFFFF, 32'hFF800000,
                            32'h00000001, 32'h80000002, 32'h3F800000, 32'hBF800000};
   logic        vn [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
                            1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   function automatic logic [32:0] res_word();
      return {bus.res_sign, bus.res_expo, bus.res_mant, bus.res_nv};
   endfunction

   task automatic drive(input int i);
      bus.in_valid = 1'b1;
      {bus.a_sign, bus.a_expo, bus.a_mant} = va[i];
      {bus.b_sign, bus.b_expo, bus.b_mant} = vb[i];
   endtask

   // Called right after a falling edge; returns right after a later falling edge.
   task automatic send(input int i, input logic exact);
      int waited = 0;
      drive(i);
      #1;
      while (!bus.in_ready && waited < 20) begin
         @(negedge clk);
         #1;
         waited++;
      end
      if (waited >= 20) begin
         check("in_ready_timeout", 64'(bus.in_ready), 64'd1);
      end else begin
         exp_q.push_back('{r: vr[i], nv: vn[i], acc: cyc, exact: exact});
         check("in_ready_accept", 64'(bus.in_ready), 64'd1);
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      bus.in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Monitor: samples mid-low-phase, after stimulus has settled.
   logic        prev_stall = 1'b0;
   logic [32:0] prev_res   = '0;

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            prev_stall = 1'b0;
         end else begin
            if (bus.out_valid && bus.out_ready) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_output", 64'(bus.out_valid), 64'd0);
               end else begin
                  e = exp_q.pop_front();
                  check("result", 64'(res_word()), 64'({e.r, e.nv}));
                  if (e.exact) check("latency", 64'(cyc - e.acc), 64'd2);
                  else check("min_latency", 64'(cyc - e.acc >= 2), 64'd1);
               end
            end
            if (bus.out_valid && !bus.out_ready) begin
               if (prev_stall) check("stall_stable", 64'(res_word()), 64'(prev_res));
               prev_stall = 1'b1;
               prev_res   = res_word();
            end else begin
               prev_stall = 1'b0;
            end
         end
      end
   end

   initial begin
      int idx;
      int accepted;
      int waited;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.a_sign = '0; bus.a_expo = '0; bus.a_mant = '0;
      bus.b_sign = '0; bus.b_expo = '0; bus.b_mant = '0;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset_out_valid", 64'(bus.out_valid), 64'd0);
      check("reset_res", 64'(res_word()), 64'd0);
      check("reset_in_ready", 64'(bus.in_ready), 64'd1);
      @(negedge clk);

      // Single transactions with gaps.
      for (int i = 0; i < 8; i++) begin
         send(i, 1'b1);
         idle(2);
      end

      // Back-to-back stream of all vectors with out_ready high.
      for (int i = 0; i < NV; i++) send(i, 1'b1);
      idle(4);

      // Backpressure: five stalled cycles while offering pairs.
      bus.out_ready = 1'b0;
      idx = 0;
      accepted = 0;
      for (int k = 0; k < 5; k++) begin
         drive(idx);
         #1;
         if (bus.in_ready) begin
            exp_q.push_back('{r: vr[idx], nv: vn[idx], acc: cyc, exact: 1'b0});
            idx++;
            accepted++;
         end
         @(negedge clk);
      end
      #1;
      check("stall_accepted", 64'(accepted), 64'd2);
      check("stall_in_ready", 64'(bus.in_ready), 64'd0);
      @(negedge clk);
      bus.out_ready = 1'b1;
      for (int i = idx; i < 10; i++) send(i, 1'b0);
      idle(4);

      // Reset with two results in flight.
      bus.out_ready = 1'b0;
      send(9, 1'b0);
      send(11, 1'b0);
      idle(1);
      #1;
      check("flight_in_ready", 64'(bus.in_ready), 64'd0);
      check("flight_out_valid", 64'(bus.out_valid), 64'd1);
      @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
      check("midrst_res", 64'(res_word()), 64'd0);
      check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
      @(negedge clk);
      bus.out_ready = 1'b1;
      send(0, 1'b1);
      send(5, 1'b1);

      // Drain.
      bus.in_valid = 1'b0;
      waited = 0;
      while (exp_q.size() != 0 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      @(negedge clk);
      check("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/fp_min_pipe.md
# fp_min_pipe

Two-stage pipelined IEEE-754 minimum unit consuming the sign/exponent/mantissa fields produced by two field-unpack stages (operands A and B) and returning the minimum in the same unpacked form. Implements minimumNumber semantics (RISC-V FMIN): NaN operands are ignored where possible, -0 < +0, and signalling NaNs raise invalid. Valid/ready handshake on both sides with full-throughput backpressure; sits between the unpack stage and the pack/writeback stage of the min datapath.

## Interface
- SIGN_W, 1, sign field width; only 1 is legal
- EXPO_W, 8, exponent field width
- MANT_W, 23, mantissa (fraction) field width

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair A/B presented
- in_ready  out  1  stage can accept operand pair this cycle
- a_sign  in  SIGN_W  operand A sign
- a_expo  in  EXPO_W  operand A biased exponent
- a_mant  in  MANT_W  operand A fraction
- b_sign, b_expo, b_mant  in  SIGN_W/EXPO_W/MANT_W  operand B fields
- out_valid  out  1  result held on res_* is valid
- out_ready  in  1  downstream accepts result this cycle
- res_sign  out  SIGN_W  result sign
- res_expo  out  EXPO_W  result exponent
- res_mant  out  MANT_W  result fraction
- res_nv  out  1  invalid-operation flag (any sNaN input)

## Operation
- Classification per operand: NaN = expo all-ones and mant != 0; sNaN = NaN with mant[MANT_W-1] = 0; qNaN = NaN with mant[MANT_W-1] = 1.
- Selection:
  - both NaN -> canonical qNaN: sign 0, expo all-ones, mant = 1 in bit MANT_W-1, 0 elsewhere.
  - exactly one NaN -> the other operand, bit-exact.
  - signs differ -> operand with sign 1 (covers -0 vs +0 -> -0).
  - both sign 0 -> smaller unsigned {expo,mant}; both sign 1 -> larger unsigned {expo,mant}.
  - magnitudes equal, same sign -> A.
- res_nv = 1 iff A or B is sNaN, regardless of which operand is returned.
- Infinities and subnormals need no special case; magnitude compare orders them correctly.
- Stage 1 (S1) registers class bits, operands and compare result (A <= B unsigned magnitude). Stage 2 (S2) registers the selected result and res_nv.
- Each stage has a valid bit. A stage loads when it is empty or its contents move on this cycle: s2_en = !s2_valid || out_ready; s1_en = !s1_valid || s2_en; in_ready = s1_en.
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Data registers load only on their stage enable; they hold otherwise.

## Timing
- Latency: 2 cycles from input transfer to out_valid with out_ready held high; throughput 1 result/cycle.
- Reset: s1_valid = 0, s2_valid = 0, out_valid = 0, res_sign = 0, res_expo = 0, res_mant = 0, res_nv = 0. in_ready = 1 in the first cycle after reset.
- in_ready is combinational from out_ready and the valid bits; there is no combinational path from in_valid or operand inputs to any output.
- Backpressure: while out_valid && !out_ready, res_* and res_nv stay stable. S1 still accepts one more pair if S1 is empty, then in_ready falls. Maximum 2 results in flight; none is dropped or duplicated.
- Simultaneous transfer in and out when full: both complete in the same cycle and the pipeline advances.
- in_valid low with S1 empty: s1_valid clears on the next enable; S2 fills bubbles as expected.
- rst asserted mid-operation: all in-flight results are discarded on that edge, with outputs at their reset values the next cycle.

## Test plan
- Defaults, A = 0x3F800000 (1.0), B = 0xC0000000 (-2.0), out_ready = 1 -> two cycles later res = {1,0x80,0x000000} (-2.0), res_nv = 0.
- A = +0, B = -0 -> res = -0 (sign 1, expo 0, mant 0); swapped order gives the same result.
- A = qNaN 0x7FC00001, B = 1.5 -> res = 1.5, res_nv = 0. A = sNaN 0x7F800001, B = 1.5 -> res = 1.5, res_nv = 1. Both sNaN -> res = 0x7FC00000, res_nv = 1.
- Stream 8 pairs back-to-back with out_ready = 1 -> in_ready stays 1 and 8 results appear on consecutive cycles, in order.
- Hold out_ready = 0 for 5 cycles during a stream -> in_ready falls after 2 accepted pairs and outputs stay stable; on release the results drain in order with none lost.
- Assert rst with 2 results in flight -> out_valid = 0 and res_* = 0 next cycle; the first post-reset pair emerges 2 cycles after acceptance.
